// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode map,
// ALU function codes, immediate-extension codes, FSM state and
// instruction-class encodings.
package multicycle_control_pkg;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_ALU_R = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_SB    = 6'b000111;

    // ALU function codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    // Immediate extension modes
    localparam logic [1:0] IMM_ZERO     = 2'b00;
    localparam logic [1:0] IMM_SIGN     = 2'b01;
    localparam logic [1:0] IMM_HI16     = 2'b10;
    localparam logic [1:0] IMM_SIGN_SH2 = 2'b11;

    typedef enum logic [2:0] {
        S_IFETCH = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU_R = 3'd0,
        CLS_ALU_I = 3'd1,
        CLS_BR    = 3'd2,
        CLS_LD    = 3'd3,
        CLS_ST    = 3'd4,
        CLS_ILL   = 3'd5
    } instr_class_e;

    // Classes whose ALU B operand is the extended immediate
    function automatic logic uses_imm(input instr_class_e cls);
        return (cls == CLS_ALU_I) || (cls == CLS_LD) || (cls == CLS_ST);
    endfunction

endpackage

// File: rtl/multicycle_control_decoder.sv
// Combinational opcode decoder: instruction class, immediate extension,
// ALU function, byte-access flag, read-port-2 select and branch kind.
module ctrl_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0]   i_op,
    input  logic [3:0]   i_func,
    output instr_class_e o_class,
    output logic [1:0]   o_immext,
    output logic [3:0]   o_alu_func,
    output logic         o_byteop,
    output logic         o_rfb_sel,
    output logic         o_br_always,
    output logic         o_br_eq,
    output logic         o_br_ne
);

    // Opcode to control-field lookup; unknown opcodes fall into CLS_ILL
    always_comb begin
        o_class     = CLS_ILL;
        o_immext    = IMM_ZERO;
        o_alu_func  = ALU_ADD;
        o_byteop    = 1'b0;
        o_br_always = 1'b0;
        o_br_eq     = 1'b0;
        o_br_ne     = 1'b0;
        case (i_op)
            OP_ALU_R: begin o_class = CLS_ALU_R; o_alu_func = i_func; end
            OP_ADDI:  begin o_class = CLS_ALU_I; o_immext = IMM_SIGN; end
            OP_ANDI:  begin o_class = CLS_ALU_I; o_alu_func = ALU_AND; end
            OP_ORI:   begin o_class = CLS_ALU_I; o_alu_func = ALU_OR; end
            OP_LI:    begin o_class = CLS_ALU_I; o_immext = IMM_SIGN; end
            OP_LUI:   begin o_class = CLS_ALU_I; o_immext = IMM_HI16; end
            OP_BEQ:   begin o_class = CLS_BR; o_immext = IMM_SIGN_SH2; o_alu_func = ALU_SUB; o_br_eq = 1'b1; end
            OP_BNE:   begin o_class = CLS_BR; o_immext = IMM_SIGN_SH2; o_alu_func = ALU_SUB; o_br_ne = 1'b1; end
            OP_B:     begin o_class = CLS_BR; o_immext = IMM_SIGN_SH2; o_alu_func = ALU_SUB; o_br_always = 1'b1; end
            OP_LW:    begin o_class = CLS_LD; o_immext = IMM_SIGN; end
            OP_LB:    begin o_class = CLS_LD; o_immext = IMM_SIGN; o_byteop = 1'b1; end
            OP_SW:    begin o_class = CLS_ST; o_immext = IMM_SIGN; end
            OP_SB:    begin o_class = CLS_ST; o_immext = IMM_SIGN; o_byteop = 1'b1; end
            default:  begin o_class = CLS_ILL; end
        endcase
        // R-type reads rt from Instr[15:11]; every other legal class reads Instr[20:16]
        o_rfb_sel = (o_class != CLS_ALU_R) && (o_class != CLS_ILL);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the IF/DEC/EX/MEM/WB MIPS datapath.
// Optional build macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: an undefined opcode
// parks the FSM in HALT until Reset; without it the opcode retires as a NOP.
// Outputs decode the registered state together with the same-cycle ALU_zero
// and MEM_Ready inputs, because branch resolution and the memory handshake
// must act in the cycle those inputs are valid.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
)
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Instr_op,
    input  logic [5:0] Instr_func,
    input  logic       ALU_zero,
    input  logic       MEM_Ready,
    output logic       PC_LdEn,
    output logic       PC_sel,
    output logic       IR_LdEn,
    output logic       RF_WrEn,
    output logic       RF_WrData_sel,
    output logic       RF_B_sel,
    output logic [1:0] ImmExt,
    output logic       ALU_Bin_sel,
    output logic [3:0] ALU_func,
    output logic       MEM_RdEn,
    output logic       MEM_WrEn,
    output logic       ByteOp,
    output logic       Bus_err
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_wait_cnt;

    instr_class_e       w_class;
    logic [1:0]         w_immext;
    logic [3:0]         w_alu_func;
    logic               w_byteop;
    logic               w_rfb_sel;
    logic               w_br_always;
    logic               w_br_eq;
    logic               w_br_ne;
    logic               w_taken;
    logic               w_timeout;
    logic               w_unused_func;

    ctrl_decoder u_decoder (
        .i_op        (Instr_op),
        .i_func      (Instr_func[3:0]),
        .o_class     (w_class),
        .o_immext    (w_immext),
        .o_alu_func  (w_alu_func),
        .o_byteop    (w_byteop),
        .o_rfb_sel   (w_rfb_sel),
        .o_br_always (w_br_always),
        .o_br_eq     (w_br_eq),
        .o_br_ne     (w_br_ne)
    );

    // Only the low four func bits select the ALU operation
    assign w_unused_func = ^Instr_func[5:4];
    assign w_taken   = w_br_always | (w_br_eq & ALU_zero) | (w_br_ne & ~ALU_zero);
    assign w_timeout = (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

    // State sequencing and MEMACC wait counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IFETCH;
            r_wait_cnt <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IFETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_class == CLS_ILL) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        r_state <= S_HALT;
`else
                        r_state <= S_WB;
`endif
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (w_class)
                        CLS_ALU_R, CLS_ALU_I: r_state <= S_WB;
                        CLS_LD, CLS_ST: begin
                            r_state    <= S_MEMACC;
                            r_wait_cnt <= {CNT_W{1'b0}};
                        end
                        default: r_state <= S_IFETCH;
                    endcase
                end
                S_MEMACC: begin
                    if (w_timeout) begin
                        r_state <= S_IFETCH;
                    end else if (MEM_Ready) begin
                        r_state <= (w_class == CLS_LD) ? S_WB : S_IFETCH;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                S_WB:    r_state <= S_IFETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IFETCH;
            endcase
        end
    end

    // Per-state output decode; everything is held low while Reset is high
    always_comb begin
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        IR_LdEn       = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ImmExt        = IMM_ZERO;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        MEM_RdEn      = 1'b0;
        MEM_WrEn      = 1'b0;
        ByteOp        = 1'b0;
        Bus_err       = 1'b0;
        if (Reset) begin
            PC_LdEn = 1'b0;
        end else begin
            case (r_state)
                S_IFETCH: IR_LdEn = 1'b1;
                S_DECODE: RF_B_sel = w_rfb_sel;
                S_EXEC: begin
                    RF_B_sel    = w_rfb_sel;
                    ImmExt      = w_immext;
                    ALU_func    = w_alu_func;
                    ALU_Bin_sel = uses_imm(w_class);
                    if (w_class == CLS_BR) begin
                        PC_LdEn = 1'b1;
                        PC_sel  = w_taken;
                    end else begin
                        PC_LdEn = 1'b0;
                    end
                end
                S_MEMACC: begin
                    RF_B_sel = w_rfb_sel;
                    if (w_timeout) begin
                        Bus_err = 1'b1;
                        PC_LdEn = 1'b1;
                    end else begin
                        MEM_RdEn = (w_class == CLS_LD);
                        MEM_WrEn = (w_class == CLS_ST);
                        ByteOp   = w_byteop;
                        PC_LdEn  = (w_class == CLS_ST) && MEM_Ready;
                    end
                end
                S_WB: begin
                    PC_LdEn       = 1'b1;
                    RF_WrEn       = (w_class != CLS_ILL);
                    RF_WrData_sel = (w_class == CLS_LD);
                end
                S_HALT:  PC_LdEn = 1'b0;
                default: PC_LdEn = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario queues per-cycle
// stimulus plus the expected output word, then drains the queue cycle by cycle.
module tb_multicycle_control;

    logic       Clk = 1'b0;
    logic       Reset, ALU_zero, MEM_Ready;
    logic [5:0] Instr_op, Instr_func;
    logic       PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel;
    logic [1:0] ImmExt;
    logic       ALU_Bin_sel;
    logic [3:0] ALU_func;
    logic       MEM_RdEn, MEM_WrEn, ByteOp, Bus_err;
    logic [16:0] w_outs;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        zero;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [16:0] exp;
    } ent_t;

    ent_t q[$];

    localparam logic [16:0] E_NONE  = 17'h00000;
    localparam logic [16:0] E_PCLD  = 17'h10000;
    localparam logic [16:0] E_PCSEL = 17'h08000;
    localparam logic [16:0] E_IR    = 17'h04000;
    localparam logic [16:0] E_RFWR  = 17'h02000;
    localparam logic [16:0] E_WDSEL = 17'h01000;
    localparam logic [16:0] E_RFB   = 17'h00800;
    localparam logic [16:0] E_BIN   = 17'h00100;
    localparam logic [16:0] E_RD    = 17'h00008;
    localparam logic [16:0] E_WR    = 17'h00004;
    localparam logic [16:0] E_BYTE  = 17'h00002;
    localparam logic [16:0] E_BERR  = 17'h00001;

    multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Instr_op(Instr_op), .Instr_func(Instr_func),
        .ALU_zero(ALU_zero), .MEM_Ready(MEM_Ready), .PC_LdEn(PC_LdEn), .PC_sel(PC_sel),
        .IR_LdEn(IR_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
        .RF_B_sel(RF_B_sel), .ImmExt(ImmExt), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .MEM_RdEn(MEM_RdEn), .MEM_WrEn(MEM_WrEn),
        .ByteOp(ByteOp), .Bus_err(Bus_err)
    );

    assign w_outs = {PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ImmExt,
                     ALU_Bin_sel, ALU_func, MEM_RdEn, MEM_WrEn, ByteOp, Bus_err};

    always #5 Clk = ~Clk;

    function automatic logic [16:0] ie(input logic [1:0] v);
        return {6'b000000, v, 9'b000000000};
    endfunction

    function automatic logic [16:0] alu(input logic [3:0] f);
        return {9'b000000000, f, 4'b0000};
    endfunction

    function automatic ent_t mk(input logic rst, input logic rdy, input logic zero,
                                input logic [5:0] op, input logic [5:0] func, input logic [16:0] exp);
        ent_t e;
        e.rst = rst; e.rdy = rdy; e.zero = zero; e.op = op; e.func = func; e.exp = exp;
        return e;
    endfunction

    task automatic drive(input ent_t e);
        Reset = e.rst; MEM_Ready = e.rdy; ALU_zero = e.zero; Instr_op = e.op; Instr_func = e.func;
    endtask

    task automatic test_reset();
        ent_t cur;
        int cyc = 0;
        q.push_back(mk(1'b1, 1'b1, 1'b1, 6'b001111, 6'b000000, E_NONE));
        q.push_back(mk(1'b1, 1'b1, 1'b1, 6'b000111, 6'b000000, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, E_RFB));
        q.push_back(mk(1'b1, 1'b1, 1'b1, 6'b000000, 6'b000000, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, E_IR));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL reset cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_alu();
        ent_t cur;
        int cyc = 0;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b100000, 6'b110000, E_NONE));
        // add: 4 cycles, ALU_func 0000 from func[3:0]
        q.push_back(mk(1'b0, 1'b0, 1'b1, 6'b100000, 6'b110000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 6'b100000, 6'b110000, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 6'b100000, 6'b110000, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 6'b100000, 6'b110000, E_PCLD | E_RFWR));
        // R-type with func 000011 -> OR
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000011, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000011, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000011, alu(4'b0011)));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000011, E_PCLD | E_RFWR));
        // ori: zero-ext immediate, OR
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110011, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110011, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110011, 6'b000000, E_RFB | E_BIN | alu(4'b0011)));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110011, 6'b000000, E_PCLD | E_RFWR));
        // lui: <<16 immediate
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111001, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111001, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111001, 6'b000000, E_RFB | ie(2'b10) | E_BIN));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111001, 6'b000000, E_PCLD | E_RFWR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111001, 6'b000000, E_IR));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL alu cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_branch();
        ent_t cur;
        int cyc = 0;
        logic [5:0] ops [5];
        logic       zs  [5];
        logic       tk  [5];
        ops = '{6'b000000, 6'b000000, 6'b000001, 6'b000001, 6'b111111};
        zs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tk  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000, E_NONE));
        for (int i = 0; i < 5; i++) begin
            q.push_back(mk(1'b0, 1'b0, zs[i], ops[i], 6'b000000, E_IR));
            q.push_back(mk(1'b0, 1'b0, zs[i], ops[i], 6'b000000, E_RFB));
            q.push_back(mk(1'b0, 1'b0, zs[i], ops[i], 6'b000000,
                           E_RFB | ie(2'b11) | alu(4'b0001) | E_PCLD | (tk[i] ? E_PCSEL : E_NONE)));
        end
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, E_IR));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL branch cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_load();
        ent_t cur;
        int cyc = 0;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b001111, 6'b000000, E_NONE));
        // lw: Ready outside MEMACC is ignored; Ready after 3 wait cycles
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b001111, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b001111, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b001111, 6'b000000, E_RFB | ie(2'b01) | E_BIN));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b001111, 6'b000000, E_RFB | E_RD));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b001111, 6'b000000, E_RFB | E_RD));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b001111, 6'b000000, E_PCLD | E_RFWR | E_WDSEL));
        // lb: Ready on the last allowed wait cycle still succeeds
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000011, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000011, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000011, 6'b000000, E_RFB | ie(2'b01) | E_BIN));
        for (int i = 0; i < 14; i++)
            q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000011, 6'b000000, E_RFB | E_RD | E_BYTE));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b000011, 6'b000000, E_RFB | E_RD | E_BYTE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000011, 6'b000000, E_PCLD | E_RFWR | E_WDSEL));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000011, 6'b000000, E_IR));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL load cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_store_timeout();
        ent_t cur;
        int cyc = 0;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b011111, 6'b000000, E_NONE));
        // sw with no Ready: 15 request cycles then a single Bus_err cycle
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b011111, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b011111, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b011111, 6'b000000, E_RFB | ie(2'b01) | E_BIN));
        for (int i = 0; i < 15; i++)
            q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b011111, 6'b000000, E_RFB | E_WR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b011111, 6'b000000, E_RFB | E_PCLD | E_BERR));
        // sb accepted on first MEMACC cycle retires in the same cycle
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_RFB | ie(2'b01) | E_BIN));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b000111, 6'b000000, E_RFB | E_WR | E_BYTE | E_PCLD));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_IR));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL store cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset_mid_access();
        ent_t cur;
        int cyc = 0;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b000111, 6'b000000, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_RFB | ie(2'b01) | E_BIN));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_RFB | E_WR | E_BYTE));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 6'b000111, 6'b000000, E_NONE));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 6'b000111, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b000111, 6'b000000, E_RFB));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL midreset cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_illegal();
        ent_t cur;
        int cyc = 0;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b010101, 6'b000000, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b010101, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b010101, 6'b000000, E_NONE));
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++)
            q.push_back(mk(1'b0, 1'b1, 1'b1, 6'b010101, 6'b000000, E_NONE));
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b010101, 6'b000000, E_NONE));
`else
        q.push_back(mk(1'b0, 1'b1, 1'b1, 6'b010101, 6'b000000, E_PCLD));
`endif
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b010101, 6'b000000, E_IR));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL illegal cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        ent_t cur;
        int cyc = 0;
        q.push_back(mk(1'b1, 1'b0, 1'b0, 6'b100000, 6'b000010, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000010, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000010, E_NONE));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000010, alu(4'b0010)));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b100000, 6'b000010, E_PCLD | E_RFWR));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 6'b000001, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 6'b000001, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 6'b000001, 6'b000000, E_RFB | ie(2'b11) | alu(4'b0001) | E_PCLD));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110010, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110010, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110010, 6'b000000, E_RFB | E_BIN | alu(4'b0010)));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b110010, 6'b000000, E_PCLD | E_RFWR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111000, 6'b000000, E_IR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111000, 6'b000000, E_RFB));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111000, 6'b000000, E_RFB | ie(2'b01) | E_BIN));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111000, 6'b000000, E_PCLD | E_RFWR));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 6'b111000, 6'b000000, E_IR));
        while (q.size() != 0) begin
            cur = q.pop_front();
            drive(cur);
            @(negedge Clk);
            n_cmp++;
            if (w_outs !== cur.exp) begin
                n_err++;
                $display("FAIL b2b cyc%0d: got %05h expected %05h", cyc, w_outs, cur.exp);
            end
            @(posedge Clk); #1;
            cyc++;
        end
    endtask

    initial begin
        Reset = 1'b1; ALU_zero = 1'b0; MEM_Ready = 1'b0;
        Instr_op = 6'b000000; Instr_func = 6'b000000;
        @(posedge Clk); #1;
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store_timeout();
        test_reset_mid_access();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
